// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: sequencer states and DLFloat (1/6/9, bias 31) constants.
package dlfloat_pkg;
  typedef enum logic [3:0] {
    IDLE, A_LO, A_HI, B_LO, B_HI, ISSUE, DRAIN, OUT_LO, OUT_HI, OUT_ST
  } state_t;
  localparam logic [15:0] DLF_NAN  = 16'hFFFF;
  localparam logic [15:0] DLF_ZERO = 16'h0000;
  localparam logic [15:0] DLF_ONE  = 16'h3E00;
endpackage

// File: rtl/dlfloat_mac_seq.sv
// dlfloat_mac_seq: byte-stream sequencer feeding the DLFloat MAC and returning the dot product.
// Define DLFLOAT_SEQ_STATUS_EN to append a status byte {6'b0, res==0, nan_seen} to each result.
module dlfloat_mac_seq import dlfloat_pkg::*; #(
  parameter int MAC_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_mac_a,
  output logic [15:0] o_mac_b,
  output logic        o_mac_en,
  output logic        o_mac_clr,
  input  logic [15:0] i_mac_acc,
  output logic        o_busy,
  output logic        o_done
);
  localparam int WW = $clog2(MAC_LAT + 1) + 1;
  state_t r_state, w_nxt;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [WW-1:0] r_wait;
  logic [15:0] r_a, r_res, r_mac_a, r_mac_b, w_res;
  logic [7:0] r_b_lo, r_out_data, w_st;
  logic r_in_ready, r_out_valid, r_mac_en, r_mac_clr, r_busy, r_done;
  logic w_in_xfer, w_out_xfer, w_last, w_exp, w_fin, w_len_acc;
  assign w_in_xfer  = r_in_ready & i_in_valid;
  assign w_out_xfer = r_out_valid & i_out_ready;
  assign w_len_acc  = (r_state == IDLE) & w_in_xfer;
  // cnt is compared before it increments, so LEN=255 ends without wrapping
  assign w_last = ({1'b0, r_cnt} + (LEN_W+1)'(1)) == {1'b0, r_len};
  assign w_exp  = r_wait == WW'(MAC_LAT);
  assign w_res  = (r_state == DRAIN && w_exp) ? i_mac_acc : r_res;
`ifdef DLFLOAT_SEQ_STATUS_EN
  logic r_nan;
  assign w_st  = {6'b0, r_res == DLF_ZERO, r_nan};
  assign w_fin = w_out_xfer & (r_state == OUT_ST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_nan <= 1'b0;
    else r_nan <= w_len_acc ? 1'b0 : r_nan
      | (r_state == ISSUE && (r_mac_a == DLF_NAN || r_mac_b == DLF_NAN))
      | (r_state == DRAIN && w_exp && i_mac_acc == DLF_NAN);
`else
  assign w_st  = 8'h00;
  assign w_fin = w_out_xfer & (r_state == OUT_HI);
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:   if (w_in_xfer) w_nxt = (i_in_data == 8'd0) ? DRAIN : A_LO;
      A_LO:   if (w_in_xfer) w_nxt = A_HI;
      A_HI:   if (w_in_xfer) w_nxt = B_LO;
      B_LO:   if (w_in_xfer) w_nxt = B_HI;
      B_HI:   if (w_in_xfer) w_nxt = ISSUE;
      ISSUE:  w_nxt = w_last ? DRAIN : A_LO;
      DRAIN:  if (w_exp) w_nxt = OUT_LO;
      OUT_LO: if (w_out_xfer) w_nxt = OUT_HI;
`ifdef DLFLOAT_SEQ_STATUS_EN
      OUT_HI: if (w_out_xfer) w_nxt = OUT_ST;
      OUT_ST: if (w_out_xfer) w_nxt = IDLE;
`else
      OUT_HI: if (w_out_xfer) w_nxt = IDLE;
`endif
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_a         <= '0;
      r_b_lo      <= '0;
      r_res       <= '0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_in_ready  <= w_nxt inside {IDLE, A_LO, A_HI, B_LO, B_HI};
      r_out_valid <= w_nxt inside {OUT_LO, OUT_HI, OUT_ST};
      r_busy      <= w_nxt != IDLE;
      r_done      <= w_fin;
      r_mac_clr   <= w_len_acc;
      r_mac_en    <= w_nxt == ISSUE;
      r_wait      <= (r_state == DRAIN) ? r_wait + WW'(1) : '0;
      r_res       <= w_res;
      if (w_len_acc) begin
        r_len <= LEN_W'(i_in_data);
        r_cnt <= '0;
      end
      if (r_state == ISSUE) r_cnt <= r_cnt + LEN_W'(1);
      if (w_in_xfer && r_state == A_LO) r_a[7:0] <= i_in_data;
      if (w_in_xfer && r_state == A_HI) r_a[15:8] <= i_in_data;
      if (w_in_xfer && r_state == B_LO) r_b_lo <= i_in_data;
      if (w_in_xfer && r_state == B_HI) begin
        r_mac_a <= r_a;
        r_mac_b <= {i_in_data, r_b_lo};
      end
      r_out_data <= (w_nxt == OUT_LO) ? w_res[7:0]
                  : (w_nxt == OUT_HI) ? r_res[15:8]
                  : (w_nxt == OUT_ST) ? w_st : 8'h00;
    end
  end
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_mac_a     = r_mac_a;
  assign o_mac_b     = r_mac_b;
  assign o_mac_en    = r_mac_en;
  assign o_mac_clr   = r_mac_clr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// tb_dlfloat_mac_seq: directed table, corner sequences and random dot products against a real-valued MAC model.
module tb_dlfloat_mac_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = 8'h00, out_data;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [15:0] mac_a, mac_b, mac_acc;
  logic mac_en, mac_clr, busy, done;
  dlfloat_mac_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_mac_a(mac_a), .o_mac_b(mac_b), .o_mac_en(mac_en), .o_mac_clr(mac_clr),
    .i_mac_acc(mac_acc), .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  int ntest = 0, nfail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic real dec(input logic [15:0] x);
    real v;
    int e;
    if (x[14:9] == 6'd0) return 0.0;
    v = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    for (int i = 0; i < e; i++) v = v * 2.0;
    for (int i = 0; i > e; i--) v = v / 2.0;
    return x[15] ? -v : v;
  endfunction
  function automatic logic [15:0] enc(input real v);
    real m;
    int e;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = v < 0.0;
    m = s ? -v : v;
    e = 31;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e > 62) return 16'hFFFF;
    if (e < 1) return 16'h0000;
    return {s, 6'(e), 9'($rtoi((m - 1.0) * 512.0))};
  endfunction
  // MAC model: product register, then accumulate register (two-cycle latency)
  real m_prod = 0.0, m_acc = 0.0;
  logic m_pv = 1'b0, m_pnan = 1'b0, m_nan = 1'b0;
  always @(posedge clk) begin
    m_pv   <= mac_en;
    m_prod <= dec(mac_a) * dec(mac_b);
    m_pnan <= (mac_a == 16'hFFFF) || (mac_b == 16'hFFFF);
    if (mac_clr) begin
      m_acc <= 0.0;
      m_nan <= 1'b0;
    end else if (m_pv) begin
      m_acc <= m_acc + m_prod;
      m_nan <= m_nan | m_pnan;
    end
  end
  always_comb mac_acc = m_nan ? 16'hFFFF : enc(m_acc);
  int cyc = 0, en_cnt = 0, clr_cnt = 0, done_cnt = 0, last_en = -100;
  always @(negedge clk) begin
    cyc++;
    if (mac_en || mac_clr) chk("en_clr_exclusive", {31'b0, mac_en & mac_clr}, 0);
    if (mac_en) begin
      chk("en_spacing_ge5", {31'b0, (cyc - last_en) >= 5}, 1);
      last_en = cyc;
      en_cnt++;
    end
    if (mac_clr) clr_cnt++;
    if (done) done_cnt++;
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [7:0] d);
    int t = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin tick(); t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic recv(output logic [7:0] d);
    int t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 2000) begin tick(); t++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    d = out_data;
    tick();
    out_ready = 1'b0;
  endtask
  logic [15:0] ja [256], jb [256];
  task automatic run_job(input int len, input logic [7:0] elo, input logic [7:0] ehi,
                         input logic [7:0] est, input string nm);
    int e0, c0, d0;
    logic [7:0] b;
    e0 = en_cnt; c0 = clr_cnt; d0 = done_cnt;
    send(8'(len));
    for (int i = 0; i < len; i++) begin
      send(ja[i][7:0]); send(ja[i][15:8]); send(jb[i][7:0]); send(jb[i][15:8]);
    end
    recv(b); chk({nm, "_lo"}, b, elo);
    recv(b); chk({nm, "_hi"}, b, ehi);
`ifdef DLFLOAT_SEQ_STATUS_EN
    recv(b); chk({nm, "_status"}, b, est);
`endif
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_low"}, busy, 0);
    tick();
    chk({nm, "_no_extra_byte"}, out_valid, 0);
    chk({nm, "_done_once"}, done_cnt - d0, 1);
    chk({nm, "_en_count"}, en_cnt - e0, len);
    chk({nm, "_clr_count"}, clr_cnt - c0, 1);
  endtask
  function automatic logic [15:0] ref_res(input int len);
    real s = 0.0;
    for (int i = 0; i < len; i++) begin
      if (ja[i] == 16'hFFFF || jb[i] == 16'hFFFF) return 16'hFFFF;
      s = s + dec(ja[i]) * dec(jb[i]);
    end
    return enc(s);
  endfunction
  function automatic logic [7:0] ref_st(input int len, input logic [15:0] r);
    logic n = r == 16'hFFFF;
    for (int i = 0; i < len; i++) n |= (ja[i] == 16'hFFFF) || (jb[i] == 16'hFFFF);
    return {6'b0, r == 16'h0000, n};
  endfunction
  typedef struct {
    int len;
    logic [15:0] a, b;
    logic [7:0] lo, hi, st;
    string nm;
  } vec_t;
  vec_t tab [5];
  task automatic run_row(input int r);
    for (int i = 0; i < tab[r].len; i++) begin ja[i] = tab[r].a; jb[i] = tab[r].b; end
    run_job(tab[r].len, tab[r].lo, tab[r].hi, tab[r].st, tab[r].nm);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] b;
    logic [15:0] r;
    int len, e0;
    // 3.0 = 1.5 * 2^1 -> exp 32, mantissa 0x100
    tab[0] = '{1, 16'h3E00, 16'h4000, 8'h00, 8'h40, 8'h00, "one_x_two"};
    tab[1] = '{3, 16'h3E00, 16'h3E00, 8'h00, 8'h41, 8'h00, "three_ones"};
    tab[2] = '{0, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h02, "len_zero"};
    tab[3] = '{1, 16'hFFFF, 16'h3E00, 8'hFF, 8'hFF, 8'h01, "nan_operand"};
    tab[4] = '{1, 16'h3E00, 16'h4000, 8'h00, 8'h40, 8'h00, "nan_cleared"};
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_en_clr", {mac_en, mac_clr}, 0);
    chk("rst_mac_ab", {mac_a, mac_b}, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    for (int r0 = 0; r0 < 5; r0++) run_row(r0);
    // abort after the A_HI transfer
    e0 = en_cnt;
    send(8'd1); send(8'h00); send(8'h3E);
    rst_n = 1'b0;
    tick();
    chk("abort_outputs", {in_ready, out_valid, out_data, mac_en, mac_clr, busy, done}, 0);
    chk("abort_mac_ab", {mac_a, mac_b}, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("abort_no_issue", en_cnt - e0, 0);
    run_row(0);
    // backpressure: stray input bytes while issuing/draining, stalled consumer in OUT_LO
    e0 = en_cnt;
    send(8'd1); send(8'h01); send(8'h3E); send(8'h00); send(8'h40);
    in_data = 8'h01;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !out_valid; t++) begin
      chk("bp_not_ready", in_ready, 0);
      tick();
    end
    for (int t = 0; t < 10; t++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h01);
      chk("bp_hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    recv(b); chk("bp_lo", b, 8'h01);
    recv(b); chk("bp_hi", b, 8'h40);
`ifdef DLFLOAT_SEQ_STATUS_EN
    recv(b); chk("bp_status", b, 8'h00);
`endif
    tick();
    chk("bp_en_count", en_cnt - e0, 1);
    chk("bp_idle", busy, 0);
    for (int j = 0; j < 21; j++) begin
      len = (j == 20) ? 255 : int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        ja[i] = {1'($urandom), 6'($urandom_range(28, 34)), 9'($urandom)};
        jb[i] = {1'($urandom), 6'($urandom_range(28, 34)), 9'($urandom)};
      end
      r = ref_res(len);
      run_job(len, r[7:0], r[15:8], ref_st(len, r), (j == 20) ? "len255" : "rand");
    end
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
